// File: rtl/clk_ctrl_pkg.sv
// Shared clock-controller definitions: monitor FSM encoding and default
// counter widths common to the divider and the pulse monitor.
package clk_ctrl_pkg;

    localparam int DEF_COUNTER_BITS = 32;
    localparam int DEF_PULSE_BITS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_STALLED  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous clock-as-data input and emits a registered
// one-cycle rise pulse; total latency from sample to rise is SYNC_STAGES+1.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d[0] = din;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/clk_pulse_monitor.sv
// Observes the divided core clock: counts rising edges, measures its period,
// checks programmed bursts for completion and flags a stalled clock.
module clk_pulse_monitor
    import clk_ctrl_pkg::*;
#(
    parameter int COUNTER_BITS   = DEF_COUNTER_BITS,
    parameter int PULSE_BITS     = DEF_PULSE_BITS,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_i,
    input  logic                    clear,
    input  logic                    write_target,
    input  logic [PULSE_BITS-1:0]   target,
    output logic [COUNTER_BITS-1:0] edge_count,
    output logic [COUNTER_BITS-1:0] period,
    output logic                    period_valid,
    output logic [PULSE_BITS-1:0]   burst_count,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout
);

    localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);

    mon_state_e              state_q, state_d;
    logic [COUNTER_BITS-1:0] edge_count_q, edge_count_d;
    logic [COUNTER_BITS-1:0] gap_q, gap_d;
    logic [COUNTER_BITS-1:0] period_q, period_d;
    logic                    period_valid_q, period_valid_d;
    logic                    seen_edge_q, seen_edge_d;
    logic [PULSE_BITS-1:0]   burst_count_q, burst_count_d;
    logic [PULSE_BITS-1:0]   target_q, target_d;
    logic [TIMER_BITS-1:0]   timer_q, timer_d;
    logic                    done_q, done_d;
    logic [PULSE_BITS-1:0]   burst_next;
    logic                    rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (clk_i),
        .rise (rise)
    );

    assign burst_next = burst_count_q + PULSE_BITS'(1);

    always_comb begin
        state_d        = state_q;
        edge_count_d   = edge_count_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        seen_edge_d    = seen_edge_q;
        burst_count_d  = burst_count_q;
        target_d       = target_q;
        timer_d        = timer_q;
        done_d         = 1'b0;
        gap_d          = (gap_q == '1) ? gap_q : gap_q + COUNTER_BITS'(1);

        if (clear) begin
            state_d        = ST_IDLE;
            edge_count_d   = '0;
            period_d       = '0;
            period_valid_d = 1'b0;
            seen_edge_d    = 1'b0;
            burst_count_d  = '0;
            timer_d        = '0;
            gap_d          = '0;
        end else begin
            if (rise) begin
                edge_count_d   = edge_count_q + COUNTER_BITS'(1);
                period_d       = (gap_q == '1) ? gap_q : gap_q + COUNTER_BITS'(1);
                gap_d          = '0;
                seen_edge_d    = 1'b1;
                period_valid_d = period_valid_q | seen_edge_q;
            end

            // A rise coinciding with a target write belongs to the old burst window.
            if (write_target) begin
                target_d = target;
                if (target == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    burst_count_d = '0;
                    timer_d       = '0;
                    state_d       = ST_COUNTING;
                end
            end else begin
                case (state_q)
                    ST_COUNTING: begin
                        if (rise) begin
                            burst_count_d = burst_next;
                            timer_d       = '0;
                            if (burst_next == target_q) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end else if (timer_q == TIMER_BITS'(TIMEOUT_CYCLES - 1)) begin
                            state_d = ST_STALLED;
                        end else begin
                            timer_d = timer_q + TIMER_BITS'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            edge_count_q   <= '0;
            gap_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seen_edge_q    <= 1'b0;
            burst_count_q  <= '0;
            target_q       <= '0;
            timer_q        <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_count_q   <= edge_count_d;
            gap_q          <= gap_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            seen_edge_q    <= seen_edge_d;
            burst_count_q  <= burst_count_d;
            target_q       <= target_d;
            timer_q        <= timer_d;
            done_q         <= done_d;
        end
    end

    assign edge_count   = edge_count_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign burst_count  = burst_count_q;
    assign done         = done_q;
    assign busy         = (state_q == ST_COUNTING);
    assign timeout      = (state_q == ST_STALLED);

endmodule

// File: tb/tb_clk_pulse_monitor.sv
module tb_clk_pulse_monitor;

    localparam int CB = 32;
    localparam int PB = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_i = 1'b0;
    logic          clear = 1'b0;
    logic          write_target = 1'b0;
    logic [PB-1:0] target = '0;
    logic [CB-1:0] edge_count, period;
    logic [PB-1:0] burst_count;
    logic          period_valid, busy, done, timeout;

    clk_pulse_monitor #(
        .COUNTER_BITS(CB), .PULSE_BITS(PB), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .clk_i(clk_i), .clear(clear),
        .write_target(write_target), .target(target),
        .edge_count(edge_count), .period(period), .period_valid(period_valid),
        .burst_count(burst_count), .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CB-1:0] ec;
        logic [CB-1:0] per;
        logic          pv;
        logic [PB-1:0] bc;
        logic          busy;
        logic          done;
        logic          tmo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    int  n = 0;
    bit  sd1 = 0, sd2 = 0, sd3 = 0, sd4 = 0;
    bit  rd1 = 1, rd2 = 1;
    int  last_ref = 0, last_act = 0;
    bit  seen = 0;
    int  mode = 0;
    longint m_tgt = 0;
    exp_t m;
    bit  finished = 0;

    initial begin
        m = '{ec: '0, per: '0, pv: 0, bc: '0, busy: 0, done: 0, tmo: 0};
    end

    always @(posedge clk) begin : model
        bit r, s;
        r = !rd1 && !rd2 && sd3 && !sd4;
        s = reset ? 1'b0 : clk_i;
        m.done = 0;
        if (reset) begin
            m.ec = 0; m.per = 0; m.pv = 0; m.bc = 0;
            mode = 0; seen = 0; last_ref = n;
        end else if (clear) begin
            m.ec = 0; m.per = 0; m.pv = 0; m.bc = 0;
            mode = 0; seen = 0; last_ref = n;
        end else begin
            if (r) begin
                m.ec = m.ec + 1;
                m.per = CB'(n - last_ref);
                if (seen) m.pv = 1;
                seen = 1;
                last_ref = n;
            end
            if (write_target) begin
                if (target == 0) begin
                    m.done = 1; mode = 0;
                end else begin
                    m.bc = 0; m_tgt = target; mode = 1; last_act = n;
                end
            end else if (mode == 1) begin
                if (r) begin
                    m.bc = m.bc + 1;
                    last_act = n;
                    if (m.bc == m_tgt) begin
                        m.done = 1; mode = 0;
                    end
                end else if (n - last_act >= TO) begin
                    mode = 2;
                end
            end
        end
        m.busy = (mode == 1);
        m.tmo  = (mode == 2);
        sd4 = sd3; sd3 = sd2; sd2 = sd1; sd1 = s;
        rd2 = rd1; rd1 = reset;
        n++;
        sb.push_back(m);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (edge_count !== e.ec || period !== e.per || period_valid !== e.pv ||
                burst_count !== e.bc || busy !== e.busy || done !== e.done ||
                timeout !== e.tmo) begin
                bad++;
                $display("FAIL outputs cyc=%0d got ec=%0d per=%0d pv=%b bc=%0d busy=%b done=%b tmo=%b want ec=%0d per=%0d pv=%b bc=%0d busy=%b done=%b tmo=%b",
                         n, edge_count, period, period_valid, burst_count, busy, done, timeout,
                         e.ec, e.per, e.pv, e.bc, e.busy, e.done, e.tmo);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        if (!finished) begin
            bad++;
            $display("FAIL timeout: stimulus did not complete");
            $finish;
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulses(input int cnt, input int hi, input int lo);
        for (int i = 0; i < cnt; i++) begin
            clk_i = 1'b1; tick(hi);
            clk_i = 1'b0; tick(lo);
        end
    endtask

    task automatic wr(input int t);
        write_target = 1'b1; target = PB'(t);
        tick();
        write_target = 1'b0;
    endtask

    initial begin
        tick(3);
        if (edge_count !== '0 || period !== '0 || period_valid !== 1'b0 ||
            burst_count !== '0 || busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset state: ec=%0d per=%0d pv=%b bc=%0d busy=%b done=%b tmo=%b",
                     edge_count, period, period_valid, burst_count, busy, done, timeout);
        end
        reset = 1'b0;
        tick(2);
        pulses(20, 2, 2);
        tick(4);
        wr(8);
        pulses(9, 1 + $urandom_range(0, 2), 1 + $urandom_range(0, 3));
        tick(6);
        wr(5);
        pulses(2, 2, 2);
        tick(30);
        wr(1);
        pulses(1, 2, 2);
        tick(6);
        wr(0);
        tick(4);
        wr(10);
        pulses(3, 2, 1);
        clear = 1'b1; write_target = 1'b1; target = 2;
        tick();
        clear = 1'b0; write_target = 1'b0;
        tick(6);
        wr(6);
        pulses(2, 2, 2);
        wr(3);
        pulses(4, 2, 2);
        tick(6);
        wr(7);
        pulses(2, 1, 1);
        clk_i = 1'b1; reset = 1'b1;
        tick();
        clk_i = 1'b0; reset = 1'b0;
        pulses(5, 1, 2);
        tick(5);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) clk_i = ~clk_i;
            write_target = ($urandom_range(0, 39) == 0);
            target = PB'($urandom_range(0, 6));
            clear = ($urandom_range(0, 89) == 0);
            reset = ($urandom_range(0, 179) == 0);
            tick();
        end
        write_target = 1'b0; clear = 1'b0; reset = 1'b0; clk_i = 1'b0;
        tick(8);
        @(negedge clk);
        #1;
        finished = 1;
        if (total == 0 || bad != 0)
            $display("FAIL summary: total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
